// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants and types for the ALU operation sequencer.
//   - ALU control codes OP_ADD..OP_SHR
//   - FSM state encoding ST_IDLE / ST_EXEC
//   - command FIFO entry layout {op, a, b, use_acc} (CMD_W bits)
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  localparam int CMD_W       = 8;
  localparam int CMD_UACC_POS = 0;
  localparam int CMD_B_LSB   = 1;
  localparam int CMD_A_LSB   = 3;
  localparam int CMD_OP_LSB  = 5;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic       use_acc;
  } cmd_t;

  function automatic cmd_t cmd_unpack(input logic [CMD_W-1:0] raw);
    cmd_t c;
    c.op      = raw[CMD_OP_LSB +: 3];
    c.a       = raw[CMD_A_LSB +: 2];
    c.b       = raw[CMD_B_LSB +: 2];
    c.use_acc = raw[CMD_UACC_POS];
    return c;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: bundles the command stream, the ALU operand/control bus and the
// result stream of the ALU operation sequencer.
//   master : the sequencer itself (accepts commands, drives the ALU, offers results)
//   slave  : the surrounding logic (issues commands, hosts the ALU, consumes results)
interface alu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_a;
  logic [1:0] cmd_b;
  logic       cmd_use_acc;
  logic       acc_clr;

  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [2:0] alu_control;
  logic [2:0] alu_result;
  logic       alu_overflow;

  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_data;
  logic       res_ovf;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, acc_clr,
    input  alu_result, alu_overflow, res_ready,
    output cmd_ready, alu_a, alu_b, alu_control,
    output res_valid, res_data, res_ovf, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, acc_clr,
    output alu_result, alu_overflow, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_control,
    input  res_valid, res_data, res_ovf, busy
  );
endinterface

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous FIFO, DEPTH entries (power of 2, >= 2) of W bits.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push/wr_data : write request, ignored while full
//   pop          : read request, ignored while empty
//   rd_data      : head entry (valid while !empty)
//   full, empty  : occupancy flags
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator for a 2-bit combinational ALU core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_if.master -- command stream in, registered ALU
//              operands/control out, ALU result/overflow in, result stream out,
//              busy status
// Commands are queued in a DEPTH-entry FIFO, issued to the ALU one at a time
// (IDLE -> EXEC -> IDLE, one op per 2 cycles) and the result is captured into
// a holding register and a 2-bit accumulator that later commands may use as A.
// Optional build macro ALU_SEQ_STATS_EN adds saturating op_count / ovf_count.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_seq_if.master       bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [7:0]      op_count,
  output logic [7:0]      ovf_count
`endif
);

  logic [0:0]       state;
  logic [1:0]       acc;
  logic [1:0]       alu_a, alu_b;
  logic [2:0]       alu_control;
  logic             res_valid;
  logic [2:0]       res_data;
  logic             res_ovf;

  cmd_t             wr_cmd, head;
  logic [CMD_W-1:0] rd_raw;
  logic             full, empty, pop;

  assign wr_cmd = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, use_acc: bus.cmd_use_acc};

  alu_seq_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.cmd_valid),
    .wr_data (wr_cmd),
    .pop     (pop),
    .rd_data (rd_raw),
    .full    (full),
    .empty   (empty)
  );

  assign head = cmd_unpack(rd_raw);

  // Only issue when the result slot is free or being freed this edge, so an
  // unconsumed result is never overwritten.
  assign pop = (state == ST_IDLE) && !empty && (!res_valid || bus.res_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_ovf     <= 1'b0;
    end else begin
      if (res_valid && bus.res_ready) res_valid <= 1'b0;

      if (state == ST_EXEC) begin
        // A new capture overrides the consume-clear above.
        res_data  <= bus.alu_result;
        res_ovf   <= bus.alu_overflow;
        res_valid <= 1'b1;
        acc       <= bus.alu_result[1:0];
        state     <= ST_IDLE;
      end else if (pop) begin
        alu_control <= head.op;
        alu_b       <= head.b;
        alu_a       <= head.use_acc ? acc : head.a;
        state       <= ST_EXEC;
      end

      // Clear has priority over the EXEC accumulator update.
      if (bus.acc_clr) acc <= '0;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (state == ST_EXEC) begin
      if (op_count != 8'hFF) op_count <= op_count + 8'd1;
      if (bus.alu_overflow && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

  assign bus.cmd_ready   = !full;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.alu_control = alu_control;
  assign bus.res_valid   = res_valid;
  assign bus.res_data    = res_data;
  assign bus.res_ovf     = res_ovf;
  assign bus.busy        = !empty || (state == ST_EXEC) || res_valid;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer.
// Hosts a behavioural 2-bit ALU on the interface and checks hand-computed
// results for single ops, accumulator chaining, back-pressure/FIFO full,
// reset mid-operation and acc_clr priority.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if bus();

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] op_count, ovf_count;
`endif

  alu_op_sequencer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_SEQ_STATS_EN
    ,
    .op_count  (op_count),
    .ovf_count (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU core.
  always_comb begin
    logic [2:0] xa, xb;
    xa = {1'b0, bus.alu_a};
    xb = {1'b0, bus.alu_b};
    bus.alu_overflow = (xa + xb) > 3'd3;
    case (bus.alu_control)
      OP_ADD:  bus.alu_result = xa + xb;
      OP_SUB:  bus.alu_result = xa - xb;
      OP_AND:  bus.alu_result = xa & xb;
      OP_OR:   bus.alu_result = xa | xb;
      OP_XOR:  bus.alu_result = xa ^ xb;
      OP_NOT:  bus.alu_result = {1'b0, ~bus.alu_a};
      OP_SHL:  bus.alu_result = {bus.alu_a, 1'b0};
      default: bus.alu_result = {2'b00, bus.alu_a[1]};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                       input logic ua);
    bus.cmd_op      = op;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_use_acc = ua;
  endtask

  // Push one command with res_ready=1 and follow it to consumption.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] a,
                        input logic [1:0] b, input logic ua, input logic [1:0] exp_a,
                        input logic [2:0] exp_res, input logic exp_ovf,
                        input logic [1:0] exp_acc);
    drive(op, a, b, ua);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk({tag, "_busy"}, 8'(bus.busy), 8'd1);
    tick();
    chk({tag, "_alu_a"}, 8'(bus.alu_a), 8'(exp_a));
    chk({tag, "_alu_b"}, 8'(bus.alu_b), 8'(b));
    chk({tag, "_ctrl"}, 8'(bus.alu_control), 8'(op));
    chk({tag, "_vld_early"}, 8'(bus.res_valid), 8'd0);
    tick();
    chk({tag, "_vld"}, 8'(bus.res_valid), 8'd1);
    chk({tag, "_data"}, 8'(bus.res_data), 8'(exp_res));
    chk({tag, "_ovf"}, 8'(bus.res_ovf), 8'(exp_ovf));
    chk({tag, "_acc"}, 8'(dut.acc), 8'(exp_acc));
    tick();
    chk({tag, "_vld_clr"}, 8'(bus.res_valid), 8'd0);
    chk({tag, "_hold_a"}, 8'(bus.alu_a), 8'(exp_a));
  endtask

  logic [2:0] q_op  [5] = '{OP_XOR, OP_OR, OP_AND, OP_NOT, OP_SHL};
  logic [1:0] q_a   [5] = '{2'd3, 2'd1, 2'd3, 2'd2, 2'd3};
  logic [1:0] q_b   [5] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
  logic [2:0] q_res [5] = '{3'b010, 3'b011, 3'b010, 3'b001, 3'b110};
  logic       q_ovf [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    bus.acc_clr   = 1'b0;
    drive(OP_ADD, 2'd0, 2'd0, 1'b0);

    // Reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cmd_ready", 8'(bus.cmd_ready), 8'd1);
    chk("rst_res_valid", 8'(bus.res_valid), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_alu_a", 8'(bus.alu_a), 8'd0);
    chk("rst_res_data", 8'(bus.res_data), 8'd0);

    // Single ops and accumulator chaining
    run_op("add32", OP_ADD, 2'd3, 2'd2, 1'b0, 2'd3, 3'b101, 1'b1, 2'b01);
    run_op("sub12", OP_SUB, 2'd1, 2'd2, 1'b0, 2'd1, 3'b111, 1'b0, 2'b11);
    run_op("add11", OP_ADD, 2'd1, 2'd1, 1'b0, 2'd1, 3'b010, 1'b0, 2'b10);
    run_op("addacc", OP_ADD, 2'd0, 2'd3, 1'b1, 2'd2, 3'b101, 1'b1, 2'b01);

    // Back-pressure: five pushes with res_ready low
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(q_op[i], q_a[i], q_b[i], 1'b0);
      bus.cmd_valid = 1'b1;
      tick();
      if (i >= 3) begin
        chk("bp_hold_vld", 8'(bus.res_valid), 8'd1);
        chk("bp_hold_data", 8'(bus.res_data), 8'(q_res[0]));
      end
    end
    bus.cmd_valid = 1'b0;
    chk("bp_full", 8'(bus.cmd_ready), 8'd0);
    tick();
    chk("bp_hold2_data", 8'(bus.res_data), 8'(q_res[0]));
    chk("bp_hold2_ovf", 8'(bus.res_ovf), 8'(q_ovf[0]));
    bus.res_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("drain_gap", 8'(bus.res_valid), 8'd0);
      if (i == 1) chk("drain_ready", 8'(bus.cmd_ready), 8'd1);
      tick();
      chk("drain_vld", 8'(bus.res_valid), 8'd1);
      chk("drain_data", 8'(bus.res_data), 8'(q_res[i]));
      chk("drain_ovf", 8'(bus.res_ovf), 8'(q_ovf[i]));
    end
    tick();
    chk("drain_idle", 8'(bus.busy), 8'd0);
    chk("drain_acc", 8'(dut.acc), 8'd2);

    // Reset while the FIFO holds 3 entries and an op is in EXEC
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    drive(OP_SHR, 2'd3, 2'd3, 1'b0); tick();
    drive(OP_ADD, 2'd1, 2'd2, 1'b0); tick();
    drive(OP_OR,  2'd0, 2'd0, 1'b0); tick();
    chk("shr_data", 8'(bus.res_data), 8'b001);
    chk("shr_ovf", 8'(bus.res_ovf), 8'd1);
    drive(OP_AND, 2'd1, 2'd1, 1'b0); tick();
    drive(OP_XOR, 2'd1, 2'd1, 1'b0);
    bus.res_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("pre_rst_ctrl", 8'(bus.alu_control), 8'(OP_ADD));
    chk("pre_rst_vld", 8'(bus.res_valid), 8'd0);
    chk("pre_rst_busy", 8'(bus.busy), 8'd1);
    chk("pre_rst_acc", 8'(dut.acc), 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", 8'(bus.res_valid), 8'd0);
    chk("mid_rst_acc", 8'(dut.acc), 8'd0);
    chk("mid_rst_busy", 8'(bus.busy), 8'd0);
    chk("mid_rst_ready", 8'(bus.cmd_ready), 8'd1);
    chk("mid_rst_ctrl", 8'(bus.alu_control), 8'd0);
    chk("mid_rst_data", 8'(bus.res_data), 8'd0);
`ifdef ALU_SEQ_STATS_EN
    chk("mid_rst_opcnt", op_count, 8'd0);
`endif
    tick();
    chk("post_rst_vld", 8'(bus.res_valid), 8'd0);
    chk("post_rst_busy", 8'(bus.busy), 8'd0);

    // acc_clr coinciding with the EXEC update
    drive(OP_ADD, 2'd1, 2'd2, 1'b0);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    chk("clr_data", 8'(bus.res_data), 8'b011);
    chk("clr_acc", 8'(dut.acc), 8'd0);
`ifdef ALU_SEQ_STATS_EN
    chk("clr_opcnt", op_count, 8'd1);
    chk("clr_ovfcnt", ovf_count, 8'd0);
`endif
    tick();
    run_op("accz", OP_ADD, 2'd3, 2'd1, 1'b1, 2'd0, 3'b001, 1'b0, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
